// File: rtl/gerador_substantivo.sv
// Transmit side of the Substantivo note protocol: one class symbol, an idle gap,
// then the all-zero terminator, each symbol opened by a one-cycle Pronto strobe.
module gerador_substantivo #(
   parameter int HOLD_CYCLES = 4,
   parameter int GAP_CYCLES  = 2
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Iniciar,
   input  logic       Cancelar,
   input  logic [1:0] Classe,
   output logic       Pronto,
   output logic       Tom,
   output logic       Nota_A,
   output logic       Nota_B,
   output logic       Nota_C,
   output logic       Ocupado,
   output logic       Concluido
);

   localparam int MAX_CYCLES = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   localparam logic [2:0] OCIOSO    = 3'd0;
   localparam logic [2:0] NOTA      = 3'd1;
   localparam logic [2:0] ESPERA    = 3'd2;
   localparam logic [2:0] FIM       = 3'd3;
   localparam logic [2:0] CONCLUIDO = 3'd4;

   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    classe_q, classe_d;
   logic          pronto_q, pronto_d;
   logic [3:0]    sym_q, sym_d;
   logic          ocupado_q, ocupado_d;
   logic          concluido_q, concluido_d;

   // Next-state logic; the counter clears on every state change and never wraps.
   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      state_d  = state_q;
      cnt_d    = cnt_q;
      classe_d = classe_q;
      case (state_q)
         OCIOSO: begin
            if (Iniciar && !Cancelar) begin
               state_d  = NOTA;
               cnt_d    = '0;
               classe_d = Classe;
            end
         end
         NOTA: begin
            if (Cancelar) begin
               state_d = OCIOSO;
               cnt_d   = '0;
            end else if (cnt_q == HOLD_LAST) begin
               state_d = (GAP_CYCLES == 0) ? FIM : ESPERA;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ESPERA: begin
            if (Cancelar) begin
               state_d = OCIOSO;
               cnt_d   = '0;
            end else if (cnt_q == GAP_LAST) begin
               state_d = FIM;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         FIM: begin
            if (Cancelar) begin
               state_d = OCIOSO;
               cnt_d   = '0;
            end else if (cnt_q == HOLD_LAST) begin
               state_d = CONCLUIDO;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = OCIOSO;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state so they are registered yet line up
   // with the state they describe; Tom=1 is the invalid-class word.
   always_comb begin
      sym_d = 4'b0000;
      if (state_d == NOTA) begin
         case (classe_d)
            2'b11:   sym_d = 4'b0011;
            2'b10:   sym_d = 4'b0100;
            2'b01:   sym_d = 4'b0101;
            default: sym_d = 4'b1000;
         endcase
      end
      pronto_d    = ((state_d == NOTA) || (state_d == FIM)) && (cnt_d == '0);
      ocupado_d   = (state_d == NOTA) || (state_d == ESPERA) || (state_d == FIM);
      concluido_d = (state_d == CONCLUIDO);
   end

   always_ff @(posedge Clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (Reset) begin
         state_q     <= OCIOSO;
         cnt_q       <= '0;
         classe_q    <= 2'b00;
         pronto_q    <= 1'b0;
         sym_q       <= 4'b0000;
         ocupado_q   <= 1'b0;
         concluido_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         classe_q    <= classe_d;
         pronto_q    <= pronto_d;
         sym_q       <= sym_d;
         ocupado_q   <= ocupado_d;
         concluido_q <= concluido_d;
      end
   end

   assign Pronto    = pronto_q;
   assign Tom       = sym_q[3];
   assign Nota_A    = sym_q[2];
   assign Nota_B    = sym_q[1];
   assign Nota_C    = sym_q[0];
   assign Ocupado   = ocupado_q;
   assign Concluido = concluido_q;

endmodule

// File: tb/tb_gerador_substantivo.sv
// Bench for gerador_substantivo: frame-level queue model checked every cycle,
// plus literal timelines for the documented scenarios and a HOLD=1/GAP=0 instance.
module tb_gerador_substantivo;

   localparam int HOLD = 4;
   localparam int GAP  = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, iniciar, cancelar;
   logic [1:0] classe;
   logic       pronto, tom, nota_a, nota_b, nota_c, ocupado, concluido;
   logic       iniciar2;
   logic [1:0] classe2;
   logic       pronto2, tom2, nota_a2, nota_b2, nota_c2, ocupado2, concluido2;

   // Vector layout: {Pronto, Tom, A, B, C, Ocupado, Concluido}
   logic [6:0] dut_vec, dut2_vec;
   assign dut_vec  = {pronto, tom, nota_a, nota_b, nota_c, ocupado, concluido};
   assign dut2_vec = {pronto2, tom2, nota_a2, nota_b2, nota_c2, ocupado2, concluido2};

   gerador_substantivo #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
      .Clk(clk), .Reset(reset), .Iniciar(iniciar), .Cancelar(cancelar), .Classe(classe),
      .Pronto(pronto), .Tom(tom), .Nota_A(nota_a), .Nota_B(nota_b), .Nota_C(nota_c),
      .Ocupado(ocupado), .Concluido(concluido)
   );

   gerador_substantivo #(.HOLD_CYCLES(1), .GAP_CYCLES(0)) dut2 (
      .Clk(clk), .Reset(reset), .Iniciar(iniciar2), .Cancelar(1'b0), .Classe(classe2),
      .Pronto(pronto2), .Tom(tom2), .Nota_A(nota_a2), .Nota_B(nota_b2), .Nota_C(nota_c2),
      .Ocupado(ocupado2), .Concluido(concluido2)
   );

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   bit model_on    = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s @%0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [3:0] word_of(input logic [1:0] c);
      case (c)
         2'b11:   return 4'b0011;
         2'b10:   return 4'b0100;
         2'b01:   return 4'b0101;
         default: return 4'b1000;
      endcase
   endfunction

   // What the classifier's Estado would settle on after receiving this word.
   function automatic logic [1:0] estado_of(input logic [3:0] w);
      if (w[3]) return 2'b00;
      case (w)
         4'b0011: return 2'b11;
         4'b0100: return 2'b10;
         4'b0101: return 2'b01;
         default: return 2'b00;
      endcase
   endfunction

   // Model: a started frame is a fixed list of per-cycle output vectors.
   logic [6:0] exp_cur = '0;
   logic [6:0] exp_fifo[$];

   task automatic push_frame(input logic [1:0] c);
      for (int i = 0; i < HOLD; i++) exp_fifo.push_back({i == 0, word_of(c), 2'b10});
      for (int i = 0; i < GAP; i++)  exp_fifo.push_back(7'b0000010);
      for (int i = 0; i < HOLD; i++) exp_fifo.push_back({i == 0, 4'b0000, 2'b10});
      exp_fifo.push_back(7'b0000001);
   endtask

   always @(posedge clk) begin
      cyc++;
      if (reset) begin
         exp_fifo.delete();
         exp_cur = '0;
      end else if (exp_cur[1] && cancelar) begin
         exp_fifo.delete();
         exp_cur = '0;
      end else if (exp_fifo.size() > 0) begin
         exp_cur = exp_fifo.pop_front();
      end else if (!exp_cur[0] && iniciar && !cancelar) begin
         push_frame(classe);
         exp_cur = exp_fifo.pop_front();
      end else begin
         exp_cur = '0;
      end
   end

   always @(negedge clk) begin
      if (model_on) check("model", 32'(dut_vec), 32'(exp_cur));
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic start_frame(input logic [1:0] c);
      classe  = c;
      iniciar = 1'b1;
      tick();
      iniciar = 1'b0;
   endtask

   logic [6:0] t2_exp [12] = '{7'b1001110, 7'b0001110, 7'b0001110, 7'b0001110,
                               7'b0000010, 7'b0000010, 7'b1000010, 7'b0000010,
                               7'b0000010, 7'b0000010, 7'b0000001, 7'b0000000};
   logic [1:0] t3_cls  [3] = '{2'b10, 2'b01, 2'b00};

   initial begin
      logic [1:0] estado;
      int         n_conc;

      reset    = 1'b1;
      iniciar  = 1'b0;
      cancelar = 1'b0;
      classe   = 2'b00;
      iniciar2 = 1'b0;
      classe2  = 2'b00;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset    = 1'b0;
      model_on = 1'b1;

      // Reset released, no stimulus.
      for (int i = 0; i < 3; i++) begin
         tick();
         check("reset_idle", 32'(dut_vec), 32'h0);
      end

      // Concreto frame, literal timeline @1..@12.
      start_frame(2'b11);
      for (int k = 0; k < 12; k++) begin
         check($sformatf("t2_c%0d", k + 1), 32'(dut_vec), 32'(t2_exp[k]));
         if (k < 11) tick();
      end

      // Remaining classes, decoded as the classifier would after the terminator.
      for (int j = 0; j < 3; j++) begin
         tick();
         start_frame(t3_cls[j]);
         estado = estado_of(dut_vec[5:2]);
         check("t3_word", 32'(dut_vec[5:2]), 32'(word_of(t3_cls[j])));
         repeat (10) tick();
         check("t3_concluido", 32'(concluido), 32'h1);
         check("t3_estado", 32'(estado), 32'(t3_cls[j]));
         tick();
      end

      // Classe change and Iniciar re-pulse mid-frame are ignored.
      tick();
      start_frame(2'b10);
      tick();
      tick();
      classe  = 2'b11;
      iniciar = 1'b1;
      n_conc  = 0;
      for (int k = 4; k <= 14; k++) begin
         tick();
         iniciar = 1'b0;
         if (k == 4) check("t4_word", 32'(dut_vec[5:2]), 32'h4);
         if (k == 11) check("t4_conc11", 32'(concluido), 32'h1);
         if (concluido) n_conc++;
      end
      check("t4_conc_count", 32'(n_conc), 32'd1);

      // Cancel at @3, restart at @5.
      start_frame(2'b01);
      tick();
      cancelar = 1'b1;
      tick();
      cancelar = 1'b0;
      check("t5_cancel4", 32'(dut_vec), 32'h0);
      tick();
      check("t5_cancel5", 32'(dut_vec), 32'h0);
      classe  = 2'b11;
      iniciar = 1'b1;
      tick();
      iniciar = 1'b0;
      check("t5_restart", 32'(dut_vec), 32'(7'b1001110));
      repeat (10) tick();
      check("t5_concluido", 32'(concluido), 32'h1);
      tick();

      // Reset at @1 of a default frame.
      start_frame(2'b11);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("t6_reset2", 32'(dut_vec), 32'h0);
      tick();
      check("t6_reset3", 32'(dut_vec), 32'h0);

      // HOLD_CYCLES=1, GAP_CYCLES=0 instance.
      classe2  = 2'b01;
      iniciar2 = 1'b1;
      tick();
      iniciar2 = 1'b0;
      check("t6_short1", 32'(dut2_vec), 32'(7'b1010110));
      tick();
      check("t6_short2", 32'(dut2_vec), 32'(7'b1000010));
      tick();
      check("t6_short3", 32'(dut2_vec), 32'(7'b0000001));
      tick();
      check("t6_short4", 32'(dut2_vec), 32'h0);

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         iniciar  = ($urandom_range(3) == 0);
         cancelar = ($urandom_range(31) == 0);
         reset    = ($urandom_range(255) == 0);
         if ($urandom_range(3) == 0) classe = 2'($urandom_range(3));
         tick();
      end
      iniciar  = 1'b0;
      cancelar = 1'b0;
      reset    = 1'b0;
      repeat (2) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
